fetch_stage_buf: RTL and testbench
==================================

// Module: fetch_stage_buf
// PURPOSE
//  Parametrised IF stage + IF/ID register with a request/response instruction-memory port,
//  a small fetch buffer, and hazard controls (stall_f, stall_d, flush_d). Sits between the
//  hazard unit, the EX-stage redirect sources (branch/JAL target, JALR ALU result) and decode.
//  Tolerates variable memory latency and discards in-flight fetches on redirect.
// PARAMETERS
//  XLEN      32            datapath / PC width
//  RESET_PC  32'h00000000  PC loaded on reset
//  FB_DEPTH  2             fetch buffer entries (power of 2, >=2); entry = {pc, instr}
//  NOP_INSTR 32'h00000013  instruction driven on instr_d for bubbles (addi x0,x0,0)
// PORTS
//  clk           in   1     clock, rising edge
//  reset         in   1     asynchronous, active-high
//  stall_f       in   1     hazard unit: do not issue new fetch
//  stall_d       in   1     hazard unit: hold IF/ID register
//  flush_d       in   1     hazard unit: bubble IF/ID register
//  pc_src_e      in   1     branch/JAL taken in EX
//  jalr_e        in   1     JALR in EX (priority over pc_src_e)
//  pc_target_e   in   XLEN  branch/JAL target
//  alu_result_e  in   XLEN  JALR target (bit 0 cleared internally)
//  imem_req      out  1     fetch request, one cycle per request
//  imem_addr     out  XLEN  byte address of request (== pc_f)
//  imem_rvalid   in   1     response valid, >=1 cycle after request
//  imem_rdata    in   32    response instruction
//  instr_d       out  32    IF/ID instruction
//  pc_d          out  XLEN  IF/ID PC
//  pc_plus4_d    out  XLEN  IF/ID PC+4 (mod 2^XLEN)
//  valid_d       out  1     IF/ID holds a real instruction
//  fb_count      out  clog2(FB_DEPTH)+1  buffer occupancy (debug/verification)
// BEHAVIOUR
//  Reset (async): pc_f=RESET_PC, FSM=S_REQ, kill=0, buffer empty, valid_d=0,
//   instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, imem_req=0 while reset high.
//  Memory protocol: at most one outstanding request; memory always accepts imem_req.
//  FSM S_REQ: imem_req = !stall_f && !redirect && (fb_count < FB_DEPTH); on issue
//   pc_f <= pc_f+4, go S_WAIT. imem_rvalid in S_REQ is ignored.
//  FSM S_WAIT: imem_req=0. On imem_rvalid: if kill, drop data, kill<=0; else push
//   {issued pc, imem_rdata} into buffer. Go S_REQ (earliest next issue: following cycle).
//  Issue gating counts the outstanding request: issue only if fb_count + 0 < FB_DEPTH in
//   S_REQ; a push in S_WAIT never overflows (guaranteed by gating).
//  Redirect = jalr_e | pc_src_e; target = jalr_e ? {alu_result_e[XLEN-1:1],1'b0} : pc_target_e.
//   Same cycle: pc_f <= target, buffer cleared, IF/ID bubbled, no issue; if S_WAIT and no
//   rvalid this cycle, kill<=1; if rvalid this cycle, data dropped. Overrides all stalls.
//  IF/ID update priority: redirect|flush_d -> bubble (valid_d=0, instr_d=NOP_INSTR, pc_d,
//   pc_plus4_d hold); else stall_d -> hold all; else buffer non-empty -> pop head into
//   IF/ID, valid_d=1; else bubble.
//  Bypass: pop and push in same cycle allowed; empty buffer + push + !stall_d loads IF/ID
//   next cycle (data is registered into buffer first; min fetch-to-decode = 2 cycles).
//  flush_d alone does not clear buffer or pc_f (hazard-unit bubble only).
//  Buffer pointers wrap modulo FB_DEPTH; fb_count never exceeds FB_DEPTH.
//  PC arithmetic modulo 2^XLEN; pc_f bits [1:0] are not checked (targets assumed aligned).
//  Reset mid-S_WAIT: outstanding response is discarded by protocol (S_REQ ignores rvalid).
// TESTING
//  1 Reset, 1-cycle memory, no stalls -> imem_addr 0,4,8,...; valid_d rises; pc_d 0,4,8
//    with pc_plus4_d = pc_d+4; steady-state throughput 1 instr / 2 cycles.
//  2 stall_d held 4 cycles -> fb_count reaches FB_DEPTH, imem_req stops, IF/ID unchanged;
//    release -> buffered instructions delivered in order, no loss or duplication.
//  3 Redirect in S_WAIT, 3-cycle memory, pc_target_e=0x100 -> stale response dropped,
//    next imem_addr=0x100, next valid pc_d=0x100, no instr from old path reaches decode.
//  4 jalr_e=1 and pc_src_e=1 together, alu_result_e=0x205, pc_target_e=0x300 ->
//    fetch from 0x204.
//  5 flush_d with stall_d same cycle -> bubble wins (valid_d=0, instr_d=0x00000013);
//    buffer contents retained and delivered next.
//  6 Async reset asserted mid-S_WAIT, rvalid arrives after release -> ignored;
//    first imem_addr = RESET_PC.

Source files
------------

// File: rtl/fetch_stage_buf.sv
// Instruction fetch stage with a small fetch buffer and the IF/ID pipeline register.
// Issues one outstanding request at a time, buffers returned {pc, instr} pairs and
// discards in-flight fetches when EX redirects the PC.
module fetch_stage_buf #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int unsigned      FB_DEPTH  = 2,
  parameter logic [31:0]      NOP_INSTR = 32'h00000013
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_f,
  input  logic                        stall_d,
  input  logic                        flush_d,
  input  logic                        pc_src_e,
  input  logic                        jalr_e,
  input  logic [XLEN-1:0]             pc_target_e,
  input  logic [XLEN-1:0]             alu_result_e,
  output logic                        imem_req,
  output logic [XLEN-1:0]             imem_addr,
  input  logic                        imem_rvalid,
  input  logic [31:0]                 imem_rdata,
  output logic [31:0]                 instr_d,
  output logic [XLEN-1:0]             pc_d,
  output logic [XLEN-1:0]             pc_plus4_d,
  output logic                        valid_d,
  output logic [$clog2(FB_DEPTH):0]   fb_count
);

  localparam int unsigned PW = $clog2(FB_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t            state, stateNext;
  logic              kill, killNext;
  logic              issue, push, pop;
  logic              redirect;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   pcF, issuedPc;
  logic [PW-1:0]     rdPtr, wrPtr;
  logic [XLEN-1:0]   pcBuf    [FB_DEPTH];
  logic [31:0]       instrBuf [FB_DEPTH];

  // JALR wins over branch/JAL; JALR target has bit 0 cleared.
  assign redirect  = jalr_e | pc_src_e;
  assign target    = jalr_e ? (alu_result_e & ~XLEN'(1)) : pc_target_e;
  assign imem_addr = pcF;
  assign imem_req  = issue & ~reset;
  assign pop       = ~redirect & ~flush_d & ~stall_d & (fb_count != '0);

  // Fetch FSM next state: issue gating, response accept/drop, kill tracking.
  always_comb begin
    stateNext = state;
    killNext  = kill;
    issue     = 1'b0;
    push      = 1'b0;
    unique case (state)
      S_REQ: begin
        issue = ~stall_f & ~redirect & (fb_count < CW'(FB_DEPTH));
        if (issue) stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          stateNext = S_REQ;
          killNext  = 1'b0;
          push      = ~kill & ~redirect;
        end else if (redirect) begin
          killNext  = 1'b1;
        end
      end
      default: stateNext = S_REQ;
    endcase
  end

  // Fetch FSM state and kill flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= stateNext;
      kill  <= killNext;
    end
  end

  // Fetch PC and the PC of the request currently outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcF      <= RESET_PC;
      issuedPc <= '0;
    end else if (redirect) begin
      pcF      <= target;
    end else if (issue) begin
      pcF      <= pcF + XLEN'(4);
      issuedPc <= pcF;
    end
  end

  // Fetch buffer storage; a slot is only read once its pointer says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pcBuf[wrPtr]    <= issuedPc;
      instrBuf[wrPtr] <= imem_rdata;
    end
  end

  // Fetch buffer pointers and occupancy; redirect empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      fb_count <= '0;
    end else if (redirect) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      fb_count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      fb_count <= fb_count + CW'(push) - CW'(pop);
    end
  end

  // IF/ID register: bubble on redirect/flush, hold on stall, else pop the buffer head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (redirect || flush_d) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
    end else if (stall_d) begin
      valid_d    <= valid_d;
    end else if (pop) begin
      valid_d    <= 1'b1;
      instr_d    <= instrBuf[rdPtr];
      pc_d       <= pcBuf[rdPtr];
      pc_plus4_d <= pcBuf[rdPtr] + XLEN'(4);
    end else begin
      valid_d    <= 1'b0;
      instr_d    <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage_buf.sv
// Bench for fetch_stage_buf: variable-latency memory, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_stage_buf;

  localparam int          FB_DEPTH = 2;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
  logic        pc_src_e = 1'b0, jalr_e = 1'b0;
  logic [31:0] pc_target_e = '0, alu_result_e = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
  logic [1:0]  fb_count;

  int checks = 0;
  int errors = 0;

  fetch_stage_buf #(.XLEN(32), .RESET_PC(32'h0), .FB_DEPTH(FB_DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .jalr_e(jalr_e), .pc_target_e(pc_target_e),
    .alu_result_e(alu_result_e), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fb_count(fb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  // Memory: one outstanding request, response memLat cycles after the request cycle.
  int          memLat = 1;
  bit          mPend = 0;
  int          mCnt = 0;
  logic [31:0] mAddr = '0;

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (mPend) begin
      mCnt--;
      if (mCnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instrOf(mAddr);
        mPend       = 0;
      end
    end
    #4;
    if (imem_req === 1'b1) begin
      chk("mem_single_outstanding", {31'b0, mPend}, 32'h0);
      mPend = 1;
      mCnt  = memLat;
      mAddr = imem_addr;
    end
  end

  // Reference model: fetch PC, outstanding-request flag, kill flag, FIFO of {pc,instr}.
  logic [31:0] mPcF = '0, mIssued = '0;
  bit          mWait = 0, mKill = 0;
  logic [63:0] mBuf[$];
  logic [63:0] mEnt;
  bit          mValid = 0;
  logic [31:0] mInstr = NOP, mPcD = '0, mPc4D = '0;
  bit          mRedir, mIssue;
  logic [31:0] mTgt;

  function automatic bit mReq();
    return !reset && !mWait && !stall_f && !(jalr_e || pc_src_e) && (mBuf.size() < FB_DEPTH);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPcF = '0; mWait = 0; mKill = 0; mBuf.delete();
      mValid = 0; mInstr = NOP; mPcD = '0; mPc4D = '0;
    end else begin
      mRedir = jalr_e || pc_src_e;
      mTgt   = jalr_e ? {alu_result_e[31:1], 1'b0} : pc_target_e;
      mIssue = mReq();
      if (mRedir || flush_d) begin
        mValid = 0; mInstr = NOP;
      end else if (!stall_d) begin
        if (mBuf.size() > 0) begin
          mEnt = mBuf.pop_front();
          mPcD = mEnt[63:32]; mInstr = mEnt[31:0]; mPc4D = mPcD + 32'd4; mValid = 1;
        end else begin
          mValid = 0; mInstr = NOP;
        end
      end
      if (mWait && imem_rvalid) begin
        if (!mKill && !mRedir) mBuf.push_back({mIssued, instrOf(mIssued)});
        mKill = 0; mWait = 0;
      end else if (mWait && mRedir) begin
        mKill = 1;
      end
      if (mRedir) begin
        mBuf.delete(); mPcF = mTgt;
      end else if (mIssue) begin
        mIssued = mPcF; mPcF = mPcF + 32'd4; mWait = 1;
      end
    end
  end

  // Per-cycle comparison against the model, after inputs settle.
  always @(negedge clk) begin
    #2;
    chk("imem_req",   {31'b0, imem_req}, {31'b0, mReq()});
    chk("imem_addr",  imem_addr, mPcF);
    chk("valid_d",    {31'b0, valid_d}, {31'b0, mValid});
    chk("instr_d",    instr_d, mInstr);
    chk("pc_d",       pc_d, mPcD);
    chk("pc_plus4_d", pc_plus4_d, mPc4D);
    chk("fb_count",   {30'b0, fb_count}, 32'(mBuf.size()));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset(input int lat);
    reset = 1'b1;
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; jalr_e = 0;
    pc_target_e = '0; alu_result_e = '0;
    cyc(4);
    memLat = lat;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: streaming with 1-cycle memory.
    cyc(3);
    reset = 1'b0;                                   // N0
    #3; chk("t1_first_req", {31'b0, imem_req}, 32'h1); chk("t1_first_addr", imem_addr, 32'h0);
    cyc(2); #3;                                     // N2
    chk("t1_addr4", imem_addr, 32'h4); chk("t1_fb1", {30'b0, fb_count}, 32'h1);
    cyc(1); #3;                                     // N3
    chk("t1_valid", {31'b0, valid_d}, 32'h1); chk("t1_pc0", pc_d, 32'h0);
    chk("t1_pc4_0", pc_plus4_d, 32'h4); chk("t1_instr0", instr_d, 32'hC0DE0000);
    cyc(2); #3;                                     // N5
    chk("t1_pc4", pc_d, 32'h4); chk("t1_pc4_4", pc_plus4_d, 32'h8);
    cyc(2); #3;                                     // N7
    chk("t1_pc8", pc_d, 32'h8);

    // Test 2: stall_d for 4 cycles fills the buffer, then drains in order.
    cyc(1); stall_d = 1;                            // N8
    cyc(2); #3;                                     // N10
    chk("t2_full", {30'b0, fb_count}, 32'h2); chk("t2_noreq", {31'b0, imem_req}, 32'h0);
    cyc(1); #3;                                     // N11
    chk("t2_hold_pc", pc_d, 32'h8);
    cyc(1); stall_d = 0;                            // N12
    cyc(1); #3; chk("t2_pc12", pc_d, 32'hC);        // N13
    cyc(1); #3; chk("t2_pc16", pc_d, 32'h10);       // N14
    cyc(2); #3; chk("t2_pc20", pc_d, 32'h14);       // N16

    // Test 3: redirect while waiting on a 3-cycle fetch.
    doReset(3);                                     // N0
    cyc(1); pc_src_e = 1; pc_target_e = 32'h100;    // N1
    #3; chk("t3_wait_noreq", {31'b0, imem_req}, 32'h0);
    cyc(1); pc_src_e = 0; pc_target_e = '0;         // N2
    cyc(2); #3;                                     // N4
    chk("t3_req", {31'b0, imem_req}, 32'h1); chk("t3_addr", imem_addr, 32'h100);
    cyc(4); #3; chk("t3_no_old", {31'b0, valid_d}, 32'h0);   // N8
    cyc(1); #3;                                     // N9
    chk("t3_valid", {31'b0, valid_d}, 32'h1); chk("t3_pc", pc_d, 32'h100);
    chk("t3_instr", instr_d, 32'hC0DE0100);

    // Test 4: JALR has priority over branch; bit 0 cleared.
    doReset(1);                                     // N0
    jalr_e = 1; pc_src_e = 1; alu_result_e = 32'h205; pc_target_e = 32'h300;
    #3; chk("t4_noreq", {31'b0, imem_req}, 32'h0);
    cyc(1); jalr_e = 0; pc_src_e = 0; alu_result_e = '0; pc_target_e = '0;  // N1
    #3; chk("t4_req", {31'b0, imem_req}, 32'h1); chk("t4_addr", imem_addr, 32'h204);
    cyc(3); #3; chk("t4_pc", pc_d, 32'h204);        // N4

    // Test 5: flush_d with stall_d bubbles but keeps buffered entries.
    doReset(1);                                     // N0
    cyc(3); stall_d = 1;                            // N3
    #3; chk("t5_pre_valid", {31'b0, valid_d}, 32'h1);
    cyc(1); flush_d = 1;                            // N4
    cyc(1); flush_d = 0; stall_d = 0;               // N5
    #3; chk("t5_bubble", {31'b0, valid_d}, 32'h0); chk("t5_nop", instr_d, 32'h00000013);
    chk("t5_pc_hold", pc_d, 32'h0); chk("t5_kept", {30'b0, fb_count}, 32'h1);
    cyc(1); #3;                                     // N6
    chk("t5_next_valid", {31'b0, valid_d}, 32'h1); chk("t5_next_pc", pc_d, 32'h4);

    // Test 6: reset mid-wait; late response must be ignored.
    doReset(3);                                     // N0
    cyc(1); reset = 1; stall_f = 1;                 // N1
    #3; chk("t6_rst_noreq", {31'b0, imem_req}, 32'h0); chk("t6_rst_valid", {31'b0, valid_d}, 32'h0);
    cyc(1); reset = 0;                              // N2
    cyc(2); #3; chk("t6_stale_dropped", {30'b0, fb_count}, 32'h0);  // N4
    stall_f = 0;
    #1; chk("t6_req", {31'b0, imem_req}, 32'h1); chk("t6_addr", imem_addr, 32'h0);
    cyc(5); #3;                                     // N9
    chk("t6_valid", {31'b0, valid_d}, 32'h1); chk("t6_pc", pc_d, 32'h0);
    chk("t6_instr", instr_d, 32'hC0DE0000);

    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
